// File: rtl/mp64_uart_rx_pkg.sv
// Shared types and constants for the mp64 UART receiver: FSM encoding,
// oversampling constants and the bit-clock divider calculation.
package mp64_uart_rx_pkg;

  typedef enum logic [2:0] {
    UART_RX_IDLE  = 3'd0,
    UART_RX_START = 3'd1,
    UART_RX_DATA  = 3'd2,
    UART_RX_STOP  = 3'd3,
    UART_RX_BREAK = 3'd4
  } uart_rx_state_e;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_SAMPLE = 8;

  // Clocks per oversample tick; never below one so the divider stays legal.
  function automatic int uart_div(input int clock_hz, input int baud);
    int div;
    div = clock_hz / (baud * UART_OVERSAMPLE);
    if (div < 32'sd1) begin
      return 32'sd1;
    end else begin
      return div;
    end
  endfunction

endpackage

// File: rtl/mp64_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count; the head entry is
// presented directly from storage, with no bypass from the write port.
module mp64_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign full      = (count_r == FULL_COUNT);
  assign do_pop_s  = pop && !empty;
  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mp64_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, buffered into a byte FIFO and
// presented on a valid/ready interface with one-cycle error pulses.
module mp64_uart_rx
  import mp64_uart_rx_pkg::*;
#(
  parameter int CLOCK_HZ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rxd_i,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_busy,
  output logic                        frame_err,
  output logic                        overrun_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV   = uart_div(CLOCK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 32'sd1);
  localparam logic [3:0] MID_LAST = 4'(UART_MID_SAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(UART_OVERSAMPLE - 1);

  logic [1:0]       sync_r;
  logic             rxd_s;
  uart_rx_state_e   state_r;
  uart_rx_state_e   state_next_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;
  logic [3:0]       tick_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             mid_start_s;
  logic             bit_end_s;
  logic             push_s;
  logic             frame_err_s;
  logic             busy_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             frame_err_r;
  logic             overrun_err_r;
  logic             rx_busy_r;

  // Two-flop synchroniser; resets to idle-high so reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd_i};
    end
  end

  assign rxd_s       = sync_r[1];
  assign tick_s      = (state_r != UART_RX_IDLE) && (div_cnt_r == DIV_LAST);
  assign mid_start_s = tick_s && (tick_cnt_r == MID_LAST);
  assign bit_end_s   = tick_s && (tick_cnt_r == BIT_LAST);

  // Oversample divider, held at zero in IDLE so ticks align to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if ((state_r == UART_RX_IDLE) || tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Tick counter restarts after mid-start so data bits sample at bit centres.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
    end else begin
      if ((state_r == UART_RX_IDLE) || ((state_r == UART_RX_START) && mid_start_s)) begin
        tick_cnt_r <= 4'd0;
      end else if (tick_s) begin
        tick_cnt_r <= tick_cnt_r + 4'd1;
      end
      if (state_r == UART_RX_START) begin
        bit_idx_r <= 3'd0;
      end else if ((state_r == UART_RX_DATA) && bit_end_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
        shift_r   <= {rxd_s, shift_r[7:1]};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= UART_RX_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      UART_RX_IDLE: begin
        if (!rxd_s) state_next_s = UART_RX_START;
        else        state_next_s = UART_RX_IDLE;
      end
      UART_RX_START: begin
        if (mid_start_s) state_next_s = rxd_s ? UART_RX_IDLE : UART_RX_DATA;
        else             state_next_s = UART_RX_START;
      end
      UART_RX_DATA: begin
        if (bit_end_s && (bit_idx_r == 3'd7)) state_next_s = UART_RX_STOP;
        else                                  state_next_s = UART_RX_DATA;
      end
      UART_RX_STOP: begin
        if (bit_end_s) state_next_s = rxd_s ? UART_RX_IDLE : UART_RX_BREAK;
        else           state_next_s = UART_RX_STOP;
      end
      UART_RX_BREAK: begin
        if (rxd_s) state_next_s = UART_RX_IDLE;
        else       state_next_s = UART_RX_BREAK;
      end
      default: state_next_s = UART_RX_IDLE;
    endcase
  end

  // FSM outputs: the stop-bit sample either delivers the byte or flags a frame error.
  always_comb begin
    push_s      = 1'b0;
    frame_err_s = 1'b0;
    if ((state_r == UART_RX_STOP) && bit_end_s) begin
      push_s      = rxd_s;
      frame_err_s = !rxd_s;
    end else begin
      push_s      = 1'b0;
      frame_err_s = 1'b0;
    end
    busy_s = (state_next_s != UART_RX_IDLE);
  end

  assign pop_s = rx_ready && !empty_s;

  // Registered status outputs; busy is taken from the next state so it tracks state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
      rx_busy_r     <= 1'b0;
    end else begin
      frame_err_r   <= frame_err_s;
      overrun_err_r <= push_s && full_s && !pop_s;
      rx_busy_r     <= busy_s;
    end
  end

  mp64_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (shift_r),
    .pop   (pop_s),
    .rdata (rx_data),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  assign rx_valid    = !empty_s;
  assign rx_busy     = rx_busy_r;
  assign frame_err   = frame_err_r;
  assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_mp64_uart_rx.sv
// Self-checking bench for mp64_uart_rx at 16 clocks per bit with a 4-deep FIFO;
// expected bytes and error counts come from a frame-level queue model.
module tb_mp64_uart_rx;

  localparam int CLOCK_HZ = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int DEPTH    = 4;
  localparam int BIT_CLK  = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int PUSH_LAT = 155;  // pin fall to the FIFO push edge: 2 sync + 1 detect + 8 + 9*16

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun_err;
  logic [CW-1:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int frame_pulses = 0;
  int overrun_pulses = 0;
  int busy_cycles = 0;
  int valid_cycles = 0;
  int valid_rise_cyc = 0;
  logic valid_q = 1'b0;
  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int exp_frame;
  int exp_overrun;

  mp64_uart_rx #(
    .CLOCK_HZ   (CLOCK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd_i       (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe on the falling edge: pulses, busy time, and every byte handed over.
  always @(negedge clk) begin
    if (frame_err) frame_pulses <= frame_pulses + 1;
    if (overrun_err) overrun_pulses <= overrun_pulses + 1;
    if (rx_busy) busy_cycles <= busy_cycles + 1;
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (rx_valid && !valid_q) valid_rise_cyc <= cyc;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    valid_q <= rx_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input byte unsigned b, input bit stop_ok);
    rxd = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(BIT_CLK);
    end
    rxd = stop_ok;
    step(BIT_CLK);
    rxd = 1'b1;
  endtask

  // Frame-level model: a good byte is kept if the consumer drains or there is room.
  task automatic model_frame(input byte unsigned b, input bit stop_ok, input bit drain);
    if (!stop_ok) exp_frame++;
    else if (drain || exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_overrun++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %0h want 0", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %0b want 0", rx_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_rx_busy: got %0b want 0", rx_busy); end
    n_cmp++; if ({frame_err, overrun_err} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %0b want 00", {frame_err, overrun_err}); end
    n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_single;
    int s, f0, o0, v0, c0;
    rx_ready = 1'b1;
    s = got_q.size(); f0 = frame_pulses; o0 = overrun_pulses; v0 = valid_cycles;
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    step(20);
    n_cmp++; if (got_q.size() !== s + 1) begin n_err++; $display("FAIL single_count: got %0d bytes want 1", got_q.size() - s); end
    else begin
      n_cmp++; if (got_q[s] !== 8'hA5) begin n_err++; $display("FAIL single_data: got %0h want a5", got_q[s]); end
    end
    n_cmp++; if (valid_cycles - v0 !== 1) begin n_err++; $display("FAIL single_valid_len: got %0d want 1", valid_cycles - v0); end
    n_cmp++; if (valid_rise_cyc - c0 !== PUSH_LAT) begin n_err++; $display("FAIL single_latency: got %0d want %0d", valid_rise_cyc - c0, PUSH_LAT); end
    n_cmp++; if (frame_pulses != f0 || overrun_pulses != o0) begin n_err++; $display("FAIL single_errs: got %0d/%0d want 0/0", frame_pulses - f0, overrun_pulses - o0); end
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int s;
    byte unsigned vals[3];
    vals = '{8'h00, 8'hFF, 8'h55};
    exp_q.delete(); exp_frame = 0; exp_overrun = 0;
    rx_ready = 1'b0;
    s = got_q.size();
    for (int i = 0; i < 3; i++) begin
      send_frame(vals[i], 1'b1);
      model_frame(vals[i], 1'b1, 1'b0);
    end
    step(20);
    n_cmp++; if (fifo_count !== CW'(exp_q.size())) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", fifo_count, exp_q.size()); end
    n_cmp++; if (rx_data !== exp_q[0]) begin n_err++; $display("FAIL b2b_head: got %0h want %0h", rx_data, exp_q[0]); end
    rx_ready = 1'b1;
    step(3);
    rx_ready = 1'b0;
    step(2);
    n_cmp++; if (got_q.size() !== s + exp_q.size()) begin n_err++; $display("FAIL b2b_pops: got %0d want %0d", got_q.size() - s, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[s+i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_order[%0d]: got %0h want %0h", i, got_q[s+i], exp_q[i]); end
      end
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got valid %0b want 0", rx_valid); end
  endtask

  task automatic test_frame_error;
    int s, f0, o0;
    byte unsigned b;
    b = 8'h3C;
    s = got_q.size(); f0 = frame_pulses; o0 = overrun_pulses;
    rx_ready = 1'b0;
    rxd = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(BIT_CLK);
    end
    rxd = 1'b0;
    step(40 * BIT_CLK);
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL break_busy: got %0b want 1", rx_busy); end
    rxd = 1'b1;
    step(40);
    n_cmp++; if (frame_pulses - f0 !== 1) begin n_err++; $display("FAIL frame_err_pulses: got %0d want 1", frame_pulses - f0); end
    n_cmp++; if (fifo_count !== '0 || overrun_pulses != o0) begin n_err++; $display("FAIL frame_err_discard: got count %0d overruns %0d want 0/0", fifo_count, overrun_pulses - o0); end
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b1);
    step(20);
    rx_ready = 1'b0;
    n_cmp++; if (got_q.size() !== s + 1) begin n_err++; $display("FAIL after_break_count: got %0d want 1", got_q.size() - s); end
    else begin
      n_cmp++; if (got_q[s] !== 8'h81) begin n_err++; $display("FAIL after_break_data: got %0h want 81", got_q[s]); end
    end
  endtask

  task automatic test_glitch;
    int s, f0, b0;
    s = got_q.size(); f0 = frame_pulses; b0 = busy_cycles;
    rxd = 1'b0;
    step(6);
    rxd = 1'b1;
    step(30);
    n_cmp++; if (busy_cycles - b0 < 6 || busy_cycles - b0 > 12) begin n_err++; $display("FAIL glitch_busy: got %0d cycles want 6..12", busy_cycles - b0); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got busy %0b want 0", rx_busy); end
    n_cmp++; if (fifo_count !== '0 || got_q.size() != s || frame_pulses != f0) begin n_err++; $display("FAIL glitch_quiet: got count %0d bytes %0d ferr %0d want 0/0/0", fifo_count, got_q.size() - s, frame_pulses - f0); end
  endtask

  task automatic test_overrun;
    int s, o0;
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.delete(); exp_frame = 0; exp_overrun = 0;
      rx_ready = 1'b0;
      o0 = overrun_pulses;
      for (int i = 1; i <= 4; i++) begin
        send_frame(8'(i), 1'b1);
        model_frame(8'(i), 1'b1, 1'b0);
      end
      if (pass == 0) begin
        send_frame(8'h05, 1'b1);
        model_frame(8'h05, 1'b1, 1'b0);
      end else begin
        fork
          send_frame(8'h05, 1'b1);
          begin step(PUSH_LAT - 1); rx_ready = 1'b1; step(1); rx_ready = 1'b0; end
        join
        void'(exp_q.pop_front());
        model_frame(8'h05, 1'b1, 1'b0);
      end
      step(20);
      n_cmp++; if (fifo_count !== CW'(exp_q.size())) begin n_err++; $display("FAIL ovr%0d_count: got %0d want %0d", pass, fifo_count, exp_q.size()); end
      n_cmp++; if (overrun_pulses - o0 !== exp_overrun) begin n_err++; $display("FAIL ovr%0d_pulses: got %0d want %0d", pass, overrun_pulses - o0, exp_overrun); end
      s = got_q.size();
      rx_ready = 1'b1;
      step(6);
      rx_ready = 1'b0;
      n_cmp++; if (got_q.size() !== s + exp_q.size()) begin n_err++; $display("FAIL ovr%0d_pops: got %0d want %0d", pass, got_q.size() - s, exp_q.size()); end
      else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++; if (got_q[s+i] !== exp_q[i]) begin n_err++; $display("FAIL ovr%0d_order[%0d]: got %0h want %0h", pass, i, got_q[s+i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int s;
    byte unsigned b;
    b = 8'h77;
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    step(20);
    n_cmp++; if (fifo_count !== CW'(1)) begin n_err++; $display("FAIL rstmid_preload: got %0d want 1", fifo_count); end
    rxd = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      step(BIT_CLK);
    end
    rxd = b[4];
    step(BIT_CLK / 2);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({rx_valid, rx_busy, frame_err, overrun_err} !== 4'b0000) begin n_err++; $display("FAIL rstmid_flags: got %0b want 0000", {rx_valid, rx_busy, frame_err, overrun_err}); end
    n_cmp++; if (fifo_count !== '0 || rx_data !== 8'h00) begin n_err++; $display("FAIL rstmid_fifo: got count %0d data %0h want 0/0", fifo_count, rx_data); end
    rxd = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(4);
    s = got_q.size();
    rx_ready = 1'b1;
    send_frame(8'h12, 1'b1);
    step(20);
    rx_ready = 1'b0;
    n_cmp++; if (got_q.size() !== s + 1) begin n_err++; $display("FAIL rstmid_next_count: got %0d want 1", got_q.size() - s); end
    else begin
      n_cmp++; if (got_q[s] !== 8'h12) begin n_err++; $display("FAIL rstmid_next_data: got %0h want 12", got_q[s]); end
    end
  endtask

  task automatic test_random;
    int s, f0, o0;
    byte unsigned b;
    bit ok;
    exp_q.delete(); exp_frame = 0; exp_overrun = 0;
    s = got_q.size(); f0 = frame_pulses; o0 = overrun_pulses;
    rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok);
      model_frame(b, ok, 1'b1);
      step(ok ? $urandom_range(0, 24) : $urandom_range(20, 40));
    end
    step(30);
    rx_ready = 1'b0;
    n_cmp++; if (frame_pulses - f0 !== exp_frame || overrun_pulses != o0) begin n_err++; $display("FAIL rand_errs: got ferr %0d ovr %0d want %0d/0", frame_pulses - f0, overrun_pulses - o0, exp_frame); end
    n_cmp++; if (got_q.size() !== s + exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - s, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got_q[s+i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data[%0d]: got %0h want %0h", i, got_q[s+i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
